clk_period_meter: RTL
=====================

// Module: clk_period_meter
// PURPOSE
//  Measures the period of a slow clock (e.g. a divider-tree output such as the 500 Hz or 1 Hz tap) in
//  cycles of the system clock. It is the checking end of the divider chain: the dividers produce slow clocks,
//  and this block receives one and reports its period, lock status and loss-of-clock.
//  It sits beside the divider tree in self-test/monitor logic; meas_clk may be asynchronous to clk.
// PARAMETERS
//  CNT_W        16     width of period counter and period output
//  TIMEOUT      50000  clk cycles without a meas_clk rise before loss-of-clock; 2 <= TIMEOUT <= 2**CNT_W-1
//  SYNC_STAGES  2      synchronizer flops on meas_clk (>=2)
// PORTS
//  clk           input   1      system clock; all logic on posedge
//  rst_n         input   1      asynchronous active-low reset
//  meas_clk      input   1      clock under measurement, async to clk, sampled as data
//  clr           input   1      synchronous clear: return to IDLE, zero all outputs
//  period        output  CNT_W  last measured period in clk cycles; held between updates
//  period_valid  output  1      one-cycle strobe when period updates
//  locked        output  1      at least one full period measured since IDLE/LOST
//  timeout       output  1      loss-of-clock flag, sticky until next meas_clk rise or clr
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, cnt=0, period=0, period_valid=0, locked=0, timeout=0,
//    synchronizer flops=0.
//  - meas_clk passes through SYNC_STAGES flops. rise = sync & ~sync_d.
//  - Detection latency: rise is seen SYNC_STAGES+1 clk edges after the meas_clk edge.
//  - period_valid and period update on the clk edge that registers the rise.
//  - FSM IDLE: cnt held 0. On rise -> MEASURE, cnt<=1.
//  - FSM MEASURE: cnt increments each cycle.
//    On rise: period<=cnt, period_valid<=1 (single cycle), locked<=1, cnt<=1.
//    A steady input of N clk cycles per period therefore reports period=N.
//    When cnt==TIMEOUT and no rise that cycle -> LOST: timeout<=1, locked<=0, period<=0.
//  - FSM LOST: cnt held 0. On rise -> MEASURE, cnt<=1, timeout<=0. No valid strobe until the next rise.
//  - The counter saturates at 2**CNT_W-1 and never wraps. TIMEOUT bounds it in normal operation.
//  - Priority in one cycle: rst_n > clr > rise > timeout.
//    clr: state=IDLE, all outputs and cnt=0; a rise in the same cycle is ignored.
//    A rise on the cycle cnt==TIMEOUT counts as a valid period of TIMEOUT; no timeout.
//  - Minimum measurable period is 2 (meas_clk high/low each >= 1 clk after synchronization).
//    Narrower pulses may be missed; this is not flagged.
// CONFIGURATION
//  CLK_PERIOD_METER_AVG_EN defined:
//   - A 4-entry history of periods is kept. period = (sum of last 4) >> 2, truncated.
//     Sum width is CNT_W+2.
//   - locked and period_valid first assert on the 4th period after IDLE/LOST, then strobe on every period.
//   - History clears on reset, clr and entry to LOST.
//  CLK_PERIOD_METER_AVG_EN not defined:
//   - period is the raw last period. locked and period_valid assert on the 1st complete period.
// STRUCTURE
//  - Package clk_meter_pkg: state enum meter_state_t {IDLE, MEASURE, LOST}, default CNT_W,
//    averaging depth constant AVG_DEPTH=4.
//  - Sub-module sync_edge_det (SYNC_STAGES param, async rst_n): synchronizer plus rise output.
//    Reusable for other divider-tap monitors.
//  - Top holds the FSM, counter, output registers and the optional averaging history.
// TESTING
//  1. rst_n=0 with meas_clk toggling -> period=0, period_valid=0, locked=0, timeout=0.
//     Release rst_n -> no valid before 2 rises.
//  2. meas_clk 5 clk high / 5 low -> every valid strobe carries period=10.
//     locked=1 from the first strobe; strobes spaced exactly 10 cycles.
//  3. meas_clk = clk/4 divider output, TIMEOUT=100, then hold meas_clk low
//     -> period=4 while running; 100 cycles after the last rise: timeout=1, locked=0, period=0.
//  4. From (3), restart meas_clk at period 6 -> timeout=0 at the first rise.
//     First strobe one period later with period=6.
//  5. clr pulsed mid-period in steady period 10; also clr coincident with a rise
//     -> all outputs 0, IDLE; next strobe only after 2 new rises, period=10.
//  6. Periods 8,8,12,12 (AVG_EN) -> no strobe on the first 3, 4th strobe period=10, locked=1.
//     Without AVG_EN -> strobes 8,8,12,12.

Source files
------------

// File: rtl/clk_period_meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clk_meter_pkg
//  Purpose  : Shared types and constants for the slow-clock period meter.
//             Provides the meter FSM state type, the default counter width
//             and the depth of the optional period-averaging history.
//  Revision : 1.0  initial release
// ============================================================================
package clk_meter_pkg;

  localparam int DEFAULT_CNT_W = 16;
  localparam int AVG_DEPTH     = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOST    = 2'd2
  } meter_state_t;

endpackage
`default_nettype wire

// File: rtl/clk_period_meter_sync_edge_det.sv
`default_nettype none
// ============================================================================
//  Module   : sync_edge_det
//  Purpose  : Multi-flop synchronizer for an asynchronous level, followed by
//             a rising-edge detector. Reusable for any divider-tap monitor.
//  Ports    : clk      in   sampling clock
//             rst_n    in   asynchronous active-low reset
//             async_in in   asynchronous input level
//             rise     out  one clk-cycle pulse on a synchronized 0->1
//  Params   : SYNC_STAGES  number of synchronizer flops (>= 2)
//  Revision : 1.0  initial release
// ============================================================================
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_sync_d <= r_sync[SYNC_STAGES-1];
    end
  end

  // Combinational so the consumer registers the edge on the next clk edge,
  // giving SYNC_STAGES+1 edges of total latency from the input edge.
  assign rise = r_sync[SYNC_STAGES-1] & ~r_sync_d;

endmodule
`default_nettype wire

// File: rtl/clk_period_meter.sv
`default_nettype none
// ============================================================================
//  Module   : clk_period_meter
//  Purpose  : Measures the period of a slow (possibly asynchronous) clock in
//             system-clock cycles; reports period, lock and loss-of-clock.
//  Ports    : clk          in   system clock
//             rst_n        in   asynchronous active-low reset
//             meas_clk     in   clock under measurement (sampled as data)
//             clr          in   synchronous clear back to IDLE
//             period       out  last measured (or averaged) period
//             period_valid out  one-cycle strobe when period updates
//             locked       out  a full period measured since IDLE/LOST
//             timeout      out  sticky loss-of-clock flag
//  Config   : CLK_PERIOD_METER_AVG_EN  report the mean of the last 4 periods
//  Revision : 1.0  initial release
// ============================================================================
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int TIMEOUT     = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             meas_clk,
  input  logic             clr,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  logic w_rise;

  meter_state_t     r_state,  w_state_nxt;
  logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
  logic [CNT_W-1:0] r_period, w_period_nxt;
  logic             r_valid,  w_valid_nxt;
  logic             r_locked, w_locked_nxt;
  logic             r_timeout, w_timeout_nxt;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (meas_clk),
    .rise     (w_rise)
  );

`ifdef CLK_PERIOD_METER_AVG_EN
  // History of completed periods, index 0 newest. r_fill counts entries up to
  // AVG_DEPTH; a strobe is allowed once the incoming period completes the set.
  localparam int                 c_fill_w     = $clog2(AVG_DEPTH) + 1;
  localparam logic [c_fill_w-1:0] c_fill_ready = c_fill_w'(AVG_DEPTH - 1);
  localparam logic [c_fill_w-1:0] c_fill_full  = c_fill_w'(AVG_DEPTH);

  logic [CNT_W-1:0]    r_hist [AVG_DEPTH];
  logic [c_fill_w-1:0] r_fill;
  logic [CNT_W+1:0]    w_sum;
  logic                w_hist_push;
  logic                w_hist_clr;

  // Sum of the period just completed plus the AVG_DEPTH-1 newest entries.
  always_comb begin
    w_sum = {2'b00, r_cnt};
    for (int i = 0; i < AVG_DEPTH - 1; i++) begin
      w_sum = w_sum + {2'b00, r_hist[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < AVG_DEPTH; i++) r_hist[i] <= '0;
      r_fill <= '0;
    end else if (w_hist_clr) begin
      for (int i = 0; i < AVG_DEPTH; i++) r_hist[i] <= '0;
      r_fill <= '0;
    end else if (w_hist_push) begin
      r_hist[0] <= r_cnt;
      for (int i = 1; i < AVG_DEPTH; i++) r_hist[i] <= r_hist[i-1];
      if (r_fill != c_fill_full) r_fill <= r_fill + c_fill_w'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_locked  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_period  <= w_period_nxt;
      r_valid   <= w_valid_nxt;
      r_locked  <= w_locked_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_period_nxt  = r_period;
    w_valid_nxt   = 1'b0;
    w_locked_nxt  = r_locked;
    w_timeout_nxt = r_timeout;
`ifdef CLK_PERIOD_METER_AVG_EN
    w_hist_push   = 1'b0;
    w_hist_clr    = 1'b0;
`endif
    if (clr) begin
      // Clear wins over a coincident rise: the rise is simply dropped.
      w_state_nxt   = IDLE;
      w_cnt_nxt     = '0;
      w_period_nxt  = '0;
      w_locked_nxt  = 1'b0;
      w_timeout_nxt = 1'b0;
`ifdef CLK_PERIOD_METER_AVG_EN
      w_hist_clr    = 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          w_cnt_nxt = '0;
          if (w_rise) begin
            w_state_nxt = MEASURE;
            w_cnt_nxt   = c_cnt_one;
          end
        end
        MEASURE: begin
          // A rise on the cnt==TIMEOUT cycle is still a valid period.
          if (w_rise) begin
            w_cnt_nxt = c_cnt_one;
`ifdef CLK_PERIOD_METER_AVG_EN
            w_hist_push = 1'b1;
            if (r_fill >= c_fill_ready) begin
              w_period_nxt = w_sum[CNT_W+1:2];
              w_valid_nxt  = 1'b1;
              w_locked_nxt = 1'b1;
            end
`else
            w_period_nxt = r_cnt;
            w_valid_nxt  = 1'b1;
            w_locked_nxt = 1'b1;
`endif
          end else if (r_cnt == c_timeout) begin
            w_state_nxt   = LOST;
            w_cnt_nxt     = '0;
            w_period_nxt  = '0;
            w_locked_nxt  = 1'b0;
            w_timeout_nxt = 1'b1;
`ifdef CLK_PERIOD_METER_AVG_EN
            w_hist_clr    = 1'b1;
`endif
          end else if (r_cnt != c_cnt_max) begin
            w_cnt_nxt = r_cnt + c_cnt_one;
          end
        end
        LOST: begin
          w_cnt_nxt = '0;
          if (w_rise) begin
            w_state_nxt   = MEASURE;
            w_cnt_nxt     = c_cnt_one;
            w_timeout_nxt = 1'b0;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign period       = r_period;
  assign period_valid = r_valid;
  assign locked       = r_locked;
  assign timeout      = r_timeout;

endmodule
`default_nettype wire
